// File: rtl/tutankham_rom_pkg.sv
// Shared ROM map for the ioctl loader and readback paths: 15 x 4KB regions at 0x0000-0xEFFF.
package tutankham_rom_pkg;

   localparam int          N_REGIONS  = 15;
   localparam int          REGION_AW  = 12;
   localparam int          IOCTL_AW   = 25;
   localparam int          BYTE_CNT_W = 17;
   localparam int          CHKSUM_W   = 16;
   localparam logic [24:0] REGION_TOP = 25'hF000;

   typedef enum logic [3:0] {
      RGN_M1, RGN_M2, RGN_M3, RGN_M4, RGN_M5, RGN_M6,
      RGN_BANK0, RGN_BANK1, RGN_BANK2, RGN_BANK3, RGN_BANK4,
      RGN_BANK5, RGN_BANK6, RGN_BANK7, RGN_BANK8
   } rgn_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} rb_state_t;

   // idx is raw addr[15:12]; it only names a real region when valid is set
   typedef struct packed {
      logic [3:0]           idx;
      logic [REGION_AW-1:0] ofs;
      logic                 valid;
   } rgn_dec_t;

endpackage

// File: rtl/rom_region_decode.sv
// Splits an ioctl byte address into region index, 4KB offset and in-map flag.
// Purely combinational; the caller registers the result.
module rom_region_decode
   import tutankham_rom_pkg::*;
(
   input  logic [IOCTL_AW-1:0] addr_i,
   output rgn_dec_t            dec_o
);

   always_comb begin
      dec_o       = '0;
      dec_o.idx   = addr_i[15:12];
      dec_o.ofs   = addr_i[REGION_AW-1:0];
      dec_o.valid = (addr_i < REGION_TOP);
   end

endmodule

// File: rtl/rom_readback.sv
// ioctl upload responder: reads one ROM byte per request, fixed 2+RD_LAT cycle latency.
// ioctl_wait stalls the HPS while a read is in flight; requests arriving then are dropped.
module rom_readback #(
   parameter int          RD_LAT    = 2,
   parameter int          N_REGIONS = tutankham_rom_pkg::N_REGIONS,
   parameter logic [7:0]  FILL      = 8'hFF
) (
   input  logic                   CLK_DL,
   input  logic                   RESET_N,
   input  logic                   ioctl_upload,
   input  logic                   ioctl_rd,
   input  logic [24:0]            ioctl_addr,
   output logic [7:0]             ioctl_din,
   output logic                   ioctl_wait,
   output logic [11:0]            RD_ADDR,
   output logic [3:0]             RD_SEL,
   output logic                   RD_EN,
   input  logic [8*N_REGIONS-1:0] RD_DATA,
   output logic [16:0]            BYTE_CNT,
   output logic [15:0]            CHECKSUM,
   output logic                   DONE
);

   import tutankham_rom_pkg::*;

   localparam int LAT_W = $clog2(RD_LAT + 1);

   rb_state_t              state_q, state_d;
   logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
   logic [REGION_AW-1:0]   rd_addr_q, rd_addr_d;
   logic [3:0]             rd_sel_q, rd_sel_d;
   logic                   rd_en_q, rd_en_d;
   logic                   valid_q, valid_d;
   logic [7:0]             din_q, din_d;
   logic                   wait_q, wait_d;
   logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [CHKSUM_W-1:0]    chksum_q, chksum_d;
   logic                   done_q, done_d;
   logic                   upload_q;

   rgn_dec_t dec;
   logic     upload_rise, upload_fall;
   logic [7:0] rd_byte;

   rom_region_decode u_decode (
      .addr_i (ioctl_addr),
      .dec_o  (dec)
   );

   assign upload_rise = ioctl_upload & ~upload_q;
   assign upload_fall = ~ioctl_upload & upload_q;

   always_comb begin
      rd_byte = '0;
      for (int i = 0; i < N_REGIONS; i++) begin
         if (rd_sel_q == 4'(i)) rd_byte = RD_DATA[8*i +: 8];
      end
   end

   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      rd_addr_d  = rd_addr_q;
      rd_sel_d   = rd_sel_q;
      rd_en_d    = rd_en_q;
      valid_d    = valid_q;
      din_d      = din_q;
      wait_d     = wait_q;
      byte_cnt_d = byte_cnt_q;
      chksum_d   = chksum_q;
      done_d     = 1'b0;

      if (upload_rise) begin
         byte_cnt_d = '0;
         chksum_d   = '0;
      end
      if (upload_fall) done_d = (byte_cnt_q != '0);

      // Losing the session mid-read drops the request without touching the result
      if (state_q != IDLE && !ioctl_upload) begin
         state_d = IDLE;
         wait_d  = 1'b0;
         rd_en_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ioctl_rd && ioctl_upload) begin
                  rd_addr_d = dec.ofs;
                  rd_sel_d  = dec.idx;
                  rd_en_d   = dec.valid;
                  valid_d   = dec.valid;
                  wait_d    = 1'b1;
                  state_d   = ISSUE;
               end
            end
            ISSUE: begin
               lat_cnt_d = LAT_W'(1);
               state_d   = (RD_LAT == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
               if (lat_cnt_q == LAT_W'(RD_LAT - 1)) state_d = CAPTURE;
               else lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
            CAPTURE: begin
               din_d      = valid_q ? rd_byte : FILL;
               wait_d     = 1'b0;
               rd_en_d    = 1'b0;
               byte_cnt_d = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 1'b1;
               chksum_d   = chksum_q + {8'h00, din_d};
               state_d    = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK_DL or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         lat_cnt_q  <= '0;
         rd_addr_q  <= '0;
         rd_sel_q   <= '0;
         rd_en_q    <= 1'b0;
         valid_q    <= 1'b0;
         din_q      <= '0;
         wait_q     <= 1'b0;
         byte_cnt_q <= '0;
         chksum_q   <= '0;
         done_q     <= 1'b0;
         upload_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_cnt_q  <= lat_cnt_d;
         rd_addr_q  <= rd_addr_d;
         rd_sel_q   <= rd_sel_d;
         rd_en_q    <= rd_en_d;
         valid_q    <= valid_d;
         din_q      <= din_d;
         wait_q     <= wait_d;
         byte_cnt_q <= byte_cnt_d;
         chksum_q   <= chksum_d;
         done_q     <= done_d;
         upload_q   <= ioctl_upload;
      end
   end

   assign ioctl_din  = din_q;
   assign ioctl_wait = wait_q;
   assign RD_ADDR    = rd_addr_q;
   assign RD_SEL     = rd_sel_q;
   assign RD_EN      = rd_en_q;
   assign BYTE_CNT   = byte_cnt_q;
   assign CHECKSUM   = chksum_q;
   assign DONE       = done_q;

endmodule
